// File: rtl/rename_retire_ctrl.sv
// In-order retire scheduler: tracks old physical rd per renamed instruction and frees them in program order.
// Optional feature macro RENAME_RETIRE_STATS_EN adds retired_regs_o / commit_stall_o counters.
module rename_retire_ctrl #(
    parameter int ISSUE_WIDTH = 4,
    parameter int PHYS_REGS   = 64,
    parameter int ROB_DEPTH   = 16,
    localparam int IW = ISSUE_WIDTH,
    localparam int PW = $clog2(PHYS_REGS),
    localparam int TW = $clog2(ROB_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IW-1:0]    alloc_valid_i,
    input  logic [IW-1:0]    alloc_has_rd_i,
    input  logic [IW*PW-1:0] alloc_old_prd_i,
    output logic             alloc_ready_o,
    output logic [IW*TW-1:0] alloc_tag_o,
    input  logic [IW-1:0]    complete_valid_i,
    input  logic [IW*TW-1:0] complete_tag_i,
    output logic [IW-1:0]    commit_valid_o,
    output logic [IW*PW-1:0] commit_phys_rd_o,
    input  logic             commit_ready_i,
    input  logic             flush_i,
    output logic [TW:0]      rob_count_o,
    output logic             rob_empty_o,
    output logic             rob_full_o
`ifdef RENAME_RETIRE_STATS_EN
    ,
    output logic [31:0]      retired_regs_o,
    output logic [31:0]      commit_stall_o
`endif
);

    typedef enum logic {RUN, HOLD} state_t;

    function automatic logic [31:0] popcount(input logic [IW-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < IW; i++) n = n + 32'(v[i]);
        return n;
    endfunction

    state_t               state;
    logic [TW-1:0]        head;
    logic [TW-1:0]        tail;
    logic [TW:0]          count;
    logic [ROB_DEPTH-1:0] ent_valid;
    logic [ROB_DEPTH-1:0] ent_done;
    logic [ROB_DEPTH-1:0] ent_has_rd;
    logic [PW-1:0]        ent_prd [ROB_DEPTH];

    logic [IW-1:0]        alloc_fire;
    logic [TW:0]          nalloc;
    logic [TW-1:0]        offs;
    logic                 stop;
    logic [TW:0]          rank;
    logic [TW-1:0]        idx;
    logic [TW:0]          nret;
    logic [TW:0]          nret_eff;
    logic [IW-1:0]        lane_valid;
    logic [IW*PW-1:0]     lane_prd;
    logic                 beat_free;
    logic                 run_load;
    logic                 retire_fire;

    assign alloc_ready_o = (count <= (TW+1)'(ROB_DEPTH - IW));
    assign alloc_fire    = alloc_valid_i & {IW{alloc_ready_o & ~flush_i}};
    assign nalloc        = (TW+1)'(popcount(alloc_fire));
    assign rob_count_o   = count;
    assign rob_empty_o   = (count == '0);
    assign rob_full_o    = (count == (TW+1)'(ROB_DEPTH));

    // Valid lanes take consecutive slots from tail; invalid lanes consume nothing.
    always_comb begin
        offs        = '0;
        alloc_tag_o = '0;
        for (int k = 0; k < IW; k++) begin
            alloc_tag_o[k*TW +: TW] = tail + offs;
            offs = offs + TW'(alloc_valid_i[k]);
        end
    end

    // Oldest-first scan; entries without a destination retire but take no commit lane.
    always_comb begin
        stop       = 1'b0;
        rank       = '0;
        idx        = '0;
        nret       = '0;
        lane_valid = '0;
        lane_prd   = '0;
        for (int i = 0; i < IW; i++) begin
            idx = head + TW'(i);
            if (!stop && ent_valid[idx] && ent_done[idx]) begin
                nret = nret + (TW+1)'(1);
                if (ent_has_rd[idx]) begin
                    for (int j = 0; j < IW; j++) begin
                        if (rank == (TW+1)'(j)) begin
                            lane_valid[j]          = 1'b1;
                            lane_prd[j*PW +: PW]   = ent_prd[idx];
                        end
                    end
                    rank = rank + (TW+1)'(1);
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    assign beat_free   = (commit_valid_o == '0) || commit_ready_i;
    assign run_load    = (state == RUN) && beat_free;
    assign retire_fire = run_load && !flush_i;
    assign nret_eff    = retire_fire ? nret : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= RUN;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            ent_valid        <= '0;
            ent_done         <= '0;
            ent_has_rd       <= '0;
            commit_valid_o   <= '0;
            commit_phys_rd_o <= '0;
        end else begin
            if (flush_i) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                ent_valid <= '0;
                ent_done  <= '0;
            end else begin
                head  <= head + TW'(nret_eff);
                tail  <= tail + TW'(nalloc);
                count <= count + nalloc - nret_eff;
                for (int k = 0; k < IW; k++) begin
                    if (complete_valid_i[k] && ent_valid[complete_tag_i[k*TW +: TW]])
                        ent_done[complete_tag_i[k*TW +: TW]] <= 1'b1;
                end
                for (int i = 0; i < IW; i++) begin
                    if ((TW+1)'(i) < nret_eff) begin
                        ent_valid[head + TW'(i)] <= 1'b0;
                        ent_done[head + TW'(i)]  <= 1'b0;
                    end
                end
                for (int k = 0; k < IW; k++) begin
                    if (alloc_fire[k]) begin
                        ent_valid[alloc_tag_o[k*TW +: TW]]  <= 1'b1;
                        ent_done[alloc_tag_o[k*TW +: TW]]   <= 1'b0;
                        ent_has_rd[alloc_tag_o[k*TW +: TW]] <= alloc_has_rd_i[k] &&
                                                               (alloc_old_prd_i[k*PW +: PW] != '0);
                    end
                end
            end
            // A beat already presented survives flush; only a free output slot loads new work.
            case (state)
                RUN: begin
                    if (!beat_free) begin
                        state <= HOLD;
                    end else begin
                        commit_valid_o   <= retire_fire ? lane_valid : '0;
                        commit_phys_rd_o <= retire_fire ? lane_prd : '0;
                    end
                end
                HOLD: begin
                    if (commit_ready_i) begin
                        state            <= RUN;
                        commit_valid_o   <= '0;
                        commit_phys_rd_o <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < IW; k++) begin
            if (alloc_fire[k]) ent_prd[alloc_tag_o[k*TW +: TW]] <= alloc_old_prd_i[k*PW +: PW];
        end
    end

`ifdef RENAME_RETIRE_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retired_regs_o <= '0;
            commit_stall_o <= '0;
        end else begin
            if ((commit_valid_o != '0) && commit_ready_i)
                retired_regs_o <= sat_add(retired_regs_o, popcount(commit_valid_o));
            if (state == HOLD)
                commit_stall_o <= sat_add(commit_stall_o, 32'd1);
        end
    end
`endif

endmodule

// File: tb/tb_rename_retire_ctrl.sv
// Scenario bench for rename_retire_ctrl: expected commit beats are queued at completion time
// and popped by a monitor on every accepted handshake.
`timescale 1ns/1ps
module tb_rename_retire_ctrl;
    localparam int IW = 4;
    localparam int PW = 6;
    localparam int TW = 4;

    typedef struct packed {
        logic [IW-1:0]    v;
        logic [IW*PW-1:0] prd;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [IW-1:0]    alloc_valid = '0;
    logic [IW-1:0]    alloc_has_rd = '0;
    logic [IW*PW-1:0] alloc_prd = '0;
    logic             alloc_ready;
    logic [IW*TW-1:0] alloc_tag;
    logic [IW-1:0]    complete_valid = '0;
    logic [IW*TW-1:0] complete_tag = '0;
    logic [IW-1:0]    commit_valid;
    logic [IW*PW-1:0] commit_phys;
    logic             commit_ready = 1'b1;
    logic             flush = 1'b0;
    logic [TW:0]      rob_count;
    logic             rob_empty;
    logic             rob_full;
`ifdef RENAME_RETIRE_STATS_EN
    logic [31:0]      retired_regs;
    logic [31:0]      commit_stall;
`endif

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    fails = 0;

    rename_retire_ctrl #(.ISSUE_WIDTH(IW), .PHYS_REGS(64), .ROB_DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_has_rd_i(alloc_has_rd), .alloc_old_prd_i(alloc_prd),
        .alloc_ready_o(alloc_ready), .alloc_tag_o(alloc_tag),
        .complete_valid_i(complete_valid), .complete_tag_i(complete_tag),
        .commit_valid_o(commit_valid), .commit_phys_rd_o(commit_phys), .commit_ready_i(commit_ready),
        .flush_i(flush), .rob_count_o(rob_count), .rob_empty_o(rob_empty), .rob_full_o(rob_full)
`ifdef RENAME_RETIRE_STATS_EN
        , .retired_regs_o(retired_regs), .commit_stall_o(commit_stall)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && commit_valid !== '0 && commit_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL commit_unexpected: got v=%b prd=%h, required no beat", commit_valid, commit_phys);
            end else begin
                mon_e = exp_q.pop_front();
                if ({commit_valid, commit_phys} !== mon_e) begin
                    fails++;
                    $display("FAIL commit_beat: got v=%b prd=%h, required v=%b prd=%h",
                             commit_valid, commit_phys, mon_e.v, mon_e.prd);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        alloc_valid = '0; alloc_has_rd = '0; alloc_prd = '0;
        complete_valid = '0; complete_tag = '0; flush = 1'b0; commit_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({rob_count, rob_empty, rob_full, alloc_ready} !== {5'd0, 1'b1, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_ctrl: got count=%0d empty=%b full=%b ready=%b, required 0 1 0 1",
                     rob_count, rob_empty, rob_full, alloc_ready);
        end
        checks++;
        if ({commit_valid, commit_phys} !== '0) begin
            fails++;
            $display("FAIL reset_commit: got v=%b prd=%h, required 0", commit_valid, commit_phys);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        alloc_valid = 4'b0001; alloc_has_rd = 4'b0001; alloc_prd = 24'd5;
        #1;
        checks++;
        if (alloc_tag[3:0] !== 4'd0) begin
            fails++; $display("FAIL s1_tag: got %0d required 0", alloc_tag[3:0]);
        end
        step();
        alloc_valid = '0;
        complete_valid = 4'b0001; complete_tag = 16'd0;
        exp_q.push_back('{v: 4'b0001, prd: 24'd5});
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd1) begin
            fails++; $display("FAIL s1_count1: got %0d required 1", rob_count);
        end
        step();
        complete_valid = '0;
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b0000) begin
            fails++; $display("FAIL s1_early: got %b required 0000", commit_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b0001 || rob_count !== 5'd0) begin
            fails++; $display("FAIL s1_latency: got v=%b count=%0d required 0001 0", commit_valid, rob_count);
        end
        step();
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b0000 || rob_empty !== 1'b1) begin
            fails++; $display("FAIL s1_after: got v=%b empty=%b required 0000 1", commit_valid, rob_empty);
        end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        alloc_valid = 4'b1111; alloc_has_rd = 4'b1111;
        alloc_prd = {6'd36, 6'd35, 6'd34, 6'd33};
        #1;
        checks++;
        if (alloc_tag !== 16'h3210) begin
            fails++; $display("FAIL s2_tags: got %h required 3210", alloc_tag);
        end
        step();
        alloc_valid = '0;
        complete_valid = 4'b0111; complete_tag = {4'd0, 4'd1, 4'd2, 4'd3};
        step();
        complete_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b0000 || rob_count !== 5'd4) begin
            fails++; $display("FAIL s2_blocked: got v=%b count=%0d required 0000 4", commit_valid, rob_count);
        end
        step();
        complete_valid = 4'b0001; complete_tag = 16'd0;
        exp_q.push_back('{v: 4'b1111, prd: {6'd36, 6'd35, 6'd34, 6'd33}});
        step();
        complete_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b1111 || rob_count !== 5'd0) begin
            fails++; $display("FAIL s2_beat: got v=%b count=%0d required 1111 0", commit_valid, rob_count);
        end
        step();
    endtask

    task automatic test_skip_lanes();
        apply_reset();
        alloc_valid = 4'b0101; alloc_has_rd = 4'b0101;
        alloc_prd = {6'd0, 6'd40, 6'd0, 6'd0};
        #1;
        checks++;
        if (alloc_tag[3:0] !== 4'd0 || alloc_tag[11:8] !== 4'd1) begin
            fails++; $display("FAIL s3_tags: got %0d,%0d required 0,1", alloc_tag[3:0], alloc_tag[11:8]);
        end
        step();
        alloc_valid = '0;
        complete_valid = 4'b0011; complete_tag = {4'd0, 4'd0, 4'd1, 4'd0};
        exp_q.push_back('{v: 4'b0001, prd: 24'd40});
        step();
        complete_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b0001 || commit_phys !== 24'd40 || rob_count !== 5'd0) begin
            fails++;
            $display("FAIL s3_beat: got v=%b prd=%h count=%0d required 0001 000028 0", commit_valid, commit_phys, rob_count);
        end
        step();
    endtask

    task automatic test_full_hold_wrap();
        logic [IW*PW-1:0] held;
        beat_t            e;
        bit               drained;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            alloc_valid = 4'b1111; alloc_has_rd = 4'b1111;
            for (int k = 0; k < IW; k++) alloc_prd[k*PW +: PW] = PW'(4*c + k + 1);
            step();
        end
        alloc_valid = '0;
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd12 || alloc_ready !== 1'b1) begin
            fails++; $display("FAIL s4_at12: got count=%0d ready=%b required 12 1", rob_count, alloc_ready);
        end
        step();
        alloc_valid = 4'b0001; alloc_prd = 24'd13;
        step();
        alloc_valid = '0;
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd13 || alloc_ready !== 1'b0 || rob_full !== 1'b0) begin
            fails++;
            $display("FAIL s4_at13: got count=%0d ready=%b full=%b required 13 0 0", rob_count, alloc_ready, rob_full);
        end
        step();
        alloc_valid = 4'b1111;
        step();
        alloc_valid = '0;
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd13) begin
            fails++; $display("FAIL s4_ignored_alloc: got count=%0d required 13", rob_count);
        end

        apply_reset();
        for (int c = 0; c < 4; c++) begin
            alloc_valid = 4'b1111; alloc_has_rd = 4'b1111;
            for (int k = 0; k < IW; k++) alloc_prd[k*PW +: PW] = PW'(4*c + k + 1);
            step();
        end
        alloc_valid = '0;
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd16 || rob_full !== 1'b1 || alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL s4_full: got count=%0d full=%b ready=%b required 16 1 0", rob_count, rob_full, alloc_ready);
        end
        step();
        commit_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            complete_valid = 4'b1111;
            e.v = 4'b1111;
            for (int k = 0; k < IW; k++) begin
                complete_tag[k*TW +: TW] = TW'(4*c + k);
                e.prd[k*PW +: PW] = PW'(4*c + k + 1);
            end
            exp_q.push_back(e);
            step();
        end
        complete_valid = '0;
        @(negedge clk);
        held = commit_phys;
        checks++;
        if (commit_valid !== 4'b1111 || commit_phys !== {6'd4, 6'd3, 6'd2, 6'd1} || rob_count !== 5'd12) begin
            fails++;
            $display("FAIL s4_first_beat: got v=%b prd=%h count=%0d required 1111 %h 12",
                     commit_valid, commit_phys, rob_count, {6'd4, 6'd3, 6'd2, 6'd1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (commit_valid !== 4'b1111 || commit_phys !== held || rob_count !== 5'd12) begin
                fails++;
                $display("FAIL s4_hold_stable: cycle %0d got v=%b prd=%h count=%0d required 1111 %h 12",
                         i, commit_valid, commit_phys, rob_count, held);
            end
        end
        step();
        commit_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 30 && !drained; i++) begin
            step();
            @(negedge clk);
            if (rob_count == 5'd0 && commit_valid == '0) drained = 1'b1;
        end
        checks++;
        if (!drained || exp_q.size() != 0) begin
            fails++; $display("FAIL s4_drain: got drained=%b pending=%0d required 1 0", drained, exp_q.size());
        end
        checks++;
        if (alloc_tag[3:0] !== 4'd0 || rob_empty !== 1'b1) begin
            fails++; $display("FAIL s4_wrap: got tag=%0d empty=%b required 0 1", alloc_tag[3:0], rob_empty);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        alloc_valid = 4'b1111; alloc_has_rd = 4'b1111;
        alloc_prd = {6'd13, 6'd12, 6'd11, 6'd10};
        step();
        alloc_valid = 4'b0011; alloc_prd = {6'd0, 6'd0, 6'd15, 6'd14};
        step();
        alloc_valid = '0;
        complete_valid = 4'b0011; complete_tag = {4'd0, 4'd0, 4'd3, 4'd2};
        step();
        complete_valid = '0;
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd6 || commit_valid !== 4'b0000) begin
            fails++; $display("FAIL s5_pre: got count=%0d v=%b required 6 0000", rob_count, commit_valid);
        end
        step();
        flush = 1'b1;
        alloc_valid = 4'b1111; alloc_prd = {6'd23, 6'd22, 6'd21, 6'd20};
        step();
        flush = 1'b0; alloc_valid = '0;
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd0 || rob_empty !== 1'b1 || commit_valid !== 4'b0000) begin
            fails++;
            $display("FAIL s5_flushed: got count=%0d empty=%b v=%b required 0 1 0000", rob_count, rob_empty, commit_valid);
        end
        step();
        alloc_valid = 4'b0001;
        #1;
        checks++;
        if (alloc_tag[3:0] !== 4'd0) begin
            fails++; $display("FAIL s5_tail: got %0d required 0", alloc_tag[3:0]);
        end
        alloc_valid = '0;
        complete_valid = 4'b0001; complete_tag = 16'd2;
        step();
        complete_valid = '0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (rob_count !== 5'd0 || commit_valid !== 4'b0000) begin
            fails++; $display("FAIL s5_stale: got count=%0d v=%b required 0 0000", rob_count, commit_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit drained;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 4'b0001; alloc_has_rd = 4'b0001; alloc_prd = 24'(20 + i);
            complete_valid = '0;
            if (i > 0) begin
                complete_valid = 4'b0001; complete_tag = 16'(i - 1);
                exp_q.push_back('{v: 4'b0001, prd: 24'(20 + i - 1)});
            end
            #1;
            checks++;
            if (alloc_tag[3:0] !== 4'(i)) begin
                fails++; $display("FAIL b2b_tag: got %0d required %0d", alloc_tag[3:0], i);
            end
            step();
        end
        alloc_valid = '0;
        complete_valid = 4'b0001; complete_tag = 16'd5;
        exp_q.push_back('{v: 4'b0001, prd: 24'd25});
        step();
        complete_valid = '0;
        drained = 1'b0;
        for (int i = 0; i < 20 && !drained; i++) begin
            step();
            @(negedge clk);
            if (rob_count == 5'd0 && commit_valid == '0 && exp_q.size() == 0) drained = 1'b1;
        end
        checks++;
        if (!drained) begin
            fails++; $display("FAIL b2b_drain: got count=%0d pending=%0d required 0 0", rob_count, exp_q.size());
        end
    endtask

    task automatic test_reset_hold();
        apply_reset();
        commit_ready = 1'b0;
        alloc_valid = 4'b0001; alloc_has_rd = 4'b0001; alloc_prd = 24'd7;
        step();
        alloc_valid = '0;
        complete_valid = 4'b0001; complete_tag = 16'd0;
        step();
        complete_valid = '0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (commit_valid !== 4'b0001) begin
            fails++; $display("FAIL rh_held: got %b required 0001", commit_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (commit_valid !== 4'b0000 || commit_phys !== '0 || rob_count !== 5'd0) begin
            fails++;
            $display("FAIL rh_async: got v=%b prd=%h count=%0d required 0 0 0", commit_valid, commit_phys, rob_count);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        commit_ready = 1'b1;
    endtask

`ifdef RENAME_RETIRE_STATS_EN
    task automatic test_stats();
        apply_reset();
        commit_ready = 1'b0;
        alloc_valid = 4'b1111; alloc_has_rd = 4'b1111;
        alloc_prd = {6'd36, 6'd35, 6'd34, 6'd33};
        step();
        alloc_valid = '0;
        complete_valid = 4'b1111; complete_tag = 16'h3210;
        exp_q.push_back('{v: 4'b1111, prd: {6'd36, 6'd35, 6'd34, 6'd33}});
        step();
        complete_valid = '0;
        step();
        repeat (3) step();
        commit_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (retired_regs !== 32'd4 || commit_stall !== 32'd3) begin
            fails++; $display("FAIL stats: got retired=%0d stall=%0d required 4 3", retired_regs, commit_stall);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_out_of_order();
        test_skip_lanes();
        test_full_hold_wrap();
        test_flush();
        test_back_to_back();
        test_reset_hold();
`ifdef RENAME_RETIRE_STATS_EN
        test_stats();
`endif
        step();
        checks++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL leftover_beats: got %0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
